stopwatch_ctrl: RTL

Sequencing FSM for the stopwatch/timer datapath. It drives the datapath's initial-value load enable, counter-register enable, counter mux select, terminal-count select and display anode reset. It generates the count tick internally and reacts to the datapath's terminal-count flag. It supports two modes: count up from zero to the loaded target, or count down from the loaded value to zero. It sits between the debounced board buttons/switches and the datapath.

---
 rtl/stopwatch_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch/timer sequencing FSM: turns debounced button edges and the datapath
// terminal-count flag into load/count enables, mux selects and status outputs.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_load,
    input  logic       btn_clear,
    input  logic       mode_down,
    input  logic       tcLimitReached,
    output logic       init_ld_en,
    output logic       count_en,
    output logic [1:0] ctrSelect,
    output logic       tcSelect,
    output logic       anReset,
    output logic       running,
    output logic       done,
    output logic [2:0] state_dbg
);
    localparam logic [2:0] ST_CLR  = 3'b000;
    localparam logic [2:0] ST_LD   = 3'b001;
    localparam logic [2:0] ST_PRE  = 3'b010;
    localparam logic [2:0] ST_STOP = 3'b011;
    localparam logic [2:0] ST_RUN  = 3'b100;
    localparam logic [2:0] ST_DONE = 3'b101;

    logic [2:0]       state, stateNext;
    logic             modeQ, startQ, loadQ, clearQ, resetQ;
    logic [CNT_W-1:0] tickCnt;
    logic             edgeStart, edgeLoad, edgeClear, tick;

    assign edgeStart = btn_start & ~startQ;
    assign edgeLoad  = btn_load  & ~loadQ;
    assign edgeClear = btn_clear & ~clearQ;
    assign tick      = (tickCnt == CNT_W'(TICK_DIV - 1));

    always_comb begin
        stateNext = state;
        case (state)
            ST_CLR:  stateNext = ST_STOP;
            ST_LD:   stateNext = ST_PRE;
            ST_PRE:  stateNext = ST_STOP;
            ST_STOP: begin
                if (edgeClear)      stateNext = ST_CLR;
                else if (edgeLoad)  stateNext = ST_LD;
                else if (edgeStart) stateNext = ST_RUN;
            end
            ST_RUN: begin
                // terminal count outranks every button
                if (tcLimitReached) stateNext = ST_DONE;
                else if (edgeClear) stateNext = ST_CLR;
                else if (edgeLoad)  stateNext = ST_LD;
                else if (edgeStart) stateNext = ST_STOP;
            end
            ST_DONE: begin
                if (edgeClear)      stateNext = ST_CLR;
                else if (edgeLoad)  stateNext = ST_LD;
                else if (edgeStart) stateNext = ST_PRE;
            end
            default: stateNext = ST_CLR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLR;
            modeQ   <= 1'b0;
            tickCnt <= '0;
            startQ  <= 1'b0;
            loadQ   <= 1'b0;
            clearQ  <= 1'b0;
        end else begin
            state  <= stateNext;
            startQ <= btn_start;
            loadQ  <= btn_load;
            clearQ <= btn_clear;
            if (state == ST_LD)
                modeQ <= mode_down;
            // counter holds across a pause and restarts from zero on resume
            if (state == ST_RUN)
                tickCnt <= tick ? '0 : tickCnt + 1'b1;
            else if (stateNext == ST_RUN)
                tickCnt <= '0;
        end
    end

    // two-stage so the scanner reset outlasts the system reset by one cycle
    always_ff @(posedge clk) begin
        resetQ  <= reset;
        anReset <= reset | resetQ;
    end

    always_comb begin
        init_ld_en = 1'b0;
        count_en   = 1'b0;
        ctrSelect  = 2'b00;
        tcSelect   = 1'b0;
        running    = 1'b0;
        done       = 1'b0;
        state_dbg  = 3'b000;
        if (!reset) begin
            tcSelect  = modeQ;
            state_dbg = state;
            case (state)
                ST_CLR: begin
                    count_en  = 1'b1;
                    ctrSelect = 2'b11;
                end
                ST_LD:  init_ld_en = 1'b1;
                ST_PRE: begin
                    count_en  = 1'b1;
                    ctrSelect = modeQ ? 2'b00 : 2'b11;
                end
                ST_STOP: ctrSelect = modeQ ? 2'b10 : 2'b01;
                ST_RUN: begin
                    running   = 1'b1;
                    count_en  = tick & ~tcLimitReached;
                    ctrSelect = modeQ ? 2'b10 : 2'b01;
                end
                ST_DONE: begin
                    done      = 1'b1;
                    ctrSelect = modeQ ? 2'b10 : 2'b01;
                end
                default: ;
            endcase
        end
    end
endmodule
